inta_sequencer: RTL

- Interrupt-acknowledge sequencer for the 8259A model.
- Tracks INTA pulses from the CPU and latches the acknowledged IR.
- In master mode, drives the cascade bus with that IR's number. In slave mode, arms the cascade comparator and releases the vector onto the data bus only on an ID match.
- Sits directly upstream of the cascade-mode block: its CAS_out and flag_compare_at_slave outputs feed that block, and it consumes that block's flag_ID_match.

---
 rtl/inta_sequencer_if.sv | 42 ++++
 rtl/inta_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer_if.sv
// Bus bundle between the CPU/priority/cascade logic and the INTA sequencer.
// The MCS80_MODE_EN macro adds the 8080 call-sequence inputs.
interface inta_sequencer_if;
    logic       INTA_n;
    logic       SP;
    logic       int_pending;
    logic [2:0] highest_ir;
    logic [7:0] icw3_slave_map;
    logic [4:0] vector_base;
    logic       flag_ID_match;
`ifdef MCS80_MODE_EN
    logic       icw4_upm;
    logic [2:0] addr_a7_a5;
    logic [7:0] addr_high;
`endif
    logic [2:0] CAS_out;
    logic       cas_drive_en;
    logic       flag_compare_at_slave;
    logic [7:0] data_out;
    logic       data_oe;
    logic       isr_set;
    logic [2:0] ack_ir;
    logic       ack_done;

    modport master (
        output INTA_n, SP, int_pending, highest_ir, icw3_slave_map, vector_base, flag_ID_match,
`ifdef MCS80_MODE_EN
        output icw4_upm, addr_a7_a5, addr_high,
`endif
        input  CAS_out, cas_drive_en, flag_compare_at_slave, data_out, data_oe, isr_set,
        input  ack_ir, ack_done
    );

    modport slave (
        input  INTA_n, SP, int_pending, highest_ir, icw3_slave_map, vector_base, flag_ID_match,
`ifdef MCS80_MODE_EN
        input  icw4_upm, addr_a7_a5, addr_high,
`endif
        output CAS_out, cas_drive_en, flag_compare_at_slave, data_out, data_oe, isr_set,
        output ack_ir, ack_done
    );
endinterface

// File: rtl/inta_sequencer.sv
// 8259A interrupt-acknowledge sequencer: tracks INTA pulses, drives CAS or vector byte.
// Define MCS80_MODE_EN for the three-pulse 8080 CALL sequence (icw4_upm=0).
module inta_sequencer #(
    parameter logic SLAVE  = 1'b0,
    parameter logic MASTER = 1'b1
) (
    input logic             clk,
    input logic             reset,
    inta_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StP1,
        StGap1,
        StP2,
`ifdef MCS80_MODE_EN
        StGap2,
        StP3,
`endif
        StDone
    } state_e;

    state_e     state_q;
    logic       inta_q;
    logic       role_q;
    logic       slv_q;
    logic [2:0] ack_ir_q;
    logic [2:0] cas_q;
    logic       cas_en_q;
    logic       cmp_q;
    logic [7:0] dout_q;
    logic       mst_oe_q;
    logic       slv_oe_q;
    logic       isr_set_q;
    logic       done_q;
`ifdef MCS80_MODE_EN
    logic       mode3_q;
`endif

    logic       fall;
    logic       rise;
    logic [2:0] ir_sel;
    logic       is_master;
    logic       slv_sel;

    always_comb begin
        fall      = inta_q & ~bus.INTA_n;
        rise      = ~inta_q & bus.INTA_n;
        ir_sel    = bus.int_pending ? bus.highest_ir : 3'd7;
        is_master = (bus.SP == MASTER);
        slv_sel   = bus.icw3_slave_map[ir_sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            inta_q    <= 1'b1;
            role_q    <= 1'b0;
            slv_q     <= 1'b0;
            ack_ir_q  <= 3'd0;
            cas_q     <= 3'd0;
            cas_en_q  <= 1'b0;
            cmp_q     <= 1'b0;
            dout_q    <= 8'h00;
            mst_oe_q  <= 1'b0;
            slv_oe_q  <= 1'b0;
            isr_set_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef MCS80_MODE_EN
            mode3_q   <= 1'b0;
`endif
        end else begin
            inta_q    <= bus.INTA_n;
            isr_set_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_q   <= StP1;
                        ack_ir_q  <= ir_sel;
                        role_q    <= bus.SP;
                        slv_q     <= slv_sel;
                        isr_set_q <= bus.int_pending;
                        cas_en_q  <= is_master & slv_sel;
                        cas_q     <= (is_master & slv_sel) ? ir_sel : 3'd0;
                        cmp_q     <= (bus.SP == SLAVE);
                        dout_q    <= 8'h00;
`ifdef MCS80_MODE_EN
                        mode3_q   <= ~bus.icw4_upm;
                        // 8080 mode: the CALL opcode goes out on the first pulse.
                        if (!bus.icw4_upm) begin
                            dout_q   <= 8'hCD;
                            mst_oe_q <= is_master & ~slv_sel;
                            slv_oe_q <= (bus.SP == SLAVE);
                        end
`endif
                    end
                end
                StP1: begin
                    if (rise) begin
                        state_q  <= StGap1;
                        mst_oe_q <= 1'b0;
                        slv_oe_q <= 1'b0;
                    end
                end
                StGap1: begin
                    if (fall) begin
                        state_q  <= StP2;
                        dout_q   <= {bus.vector_base, ack_ir_q};
`ifdef MCS80_MODE_EN
                        if (mode3_q) dout_q <= {bus.addr_a7_a5, ack_ir_q, 2'b00};
`endif
                        mst_oe_q <= (role_q == MASTER) & ~slv_q;
                        slv_oe_q <= (role_q == SLAVE);
                    end
                end
                StP2: begin
                    if (rise) begin
`ifdef MCS80_MODE_EN
                        if (mode3_q) begin
                            state_q  <= StGap2;
                            mst_oe_q <= 1'b0;
                            slv_oe_q <= 1'b0;
                        end else
`endif
                        begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            cas_q    <= 3'd0;
                            cas_en_q <= 1'b0;
                            cmp_q    <= 1'b0;
                            mst_oe_q <= 1'b0;
                            slv_oe_q <= 1'b0;
                        end
                    end
                end
`ifdef MCS80_MODE_EN
                StGap2: begin
                    if (fall) begin
                        state_q  <= StP3;
                        dout_q   <= bus.addr_high;
                        mst_oe_q <= (role_q == MASTER) & ~slv_q;
                        slv_oe_q <= (role_q == SLAVE);
                    end
                end
                StP3: begin
                    if (rise) begin
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        cas_q    <= 3'd0;
                        cas_en_q <= 1'b0;
                        cmp_q    <= 1'b0;
                        mst_oe_q <= 1'b0;
                        slv_oe_q <= 1'b0;
                    end
                end
`endif
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // A slave only releases its vector while the cascade comparator reports a match.
    assign bus.data_oe               = mst_oe_q | (slv_oe_q & bus.flag_ID_match);
    assign bus.CAS_out               = cas_q;
    assign bus.cas_drive_en          = cas_en_q;
    assign bus.flag_compare_at_slave = cmp_q;
    assign bus.data_out              = dout_q;
    assign bus.isr_set               = isr_set_q;
    assign bus.ack_ir                = ack_ir_q;
    assign bus.ack_done              = done_q;

endmodule
